// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access (data wins).
// Optional access watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic [DW/8-1:0] dm_wstrb,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_ack,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            waiting,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t state;
  logic   busy;
  logic   timeout;
  logic   done;

  assign busy = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Watchdog: counts BUSY cycles without an ack; any ack or a return to IDLE clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!busy || mem_ack || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The limit is hit in the cycle the count would reach TIMEOUT_CYC; a real ack in that cycle wins.
  assign timeout = busy && !mem_ack && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC == 0);
  assign timeout    = 1'b0;
`endif

  // Requester acks follow mem_ack in the same cycle; read data is gated off outside an ack.
  always_comb begin
    done     = 1'b0;
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    if (busy) begin
      done = mem_ack | timeout;
    end else begin
      done = 1'b0;
    end
    case (state)
      IF_BUSY: if_ack = done;
      DM_BUSY: dm_ack = done;
      default: begin
        if_ack = 1'b0;
        dm_ack = 1'b0;
      end
    endcase
    if (if_ack && !timeout) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = '0;
    end
    if (dm_ack && !timeout) begin
      dm_rdata = mem_rdata;
    end else begin
      dm_rdata = '0;
    end
    err     = timeout;
    waiting = (if_req & ~if_ack) | (dm_req & ~dm_ack);
  end

  // Grant FSM with registered memory-side request, address, strobes and store data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= dm_addr;
            mem_we    <= dm_wstrb;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= if_addr;
            mem_we    <= '0;
            mem_wdata <= '0;
          end else begin
            mem_req <= 1'b0;
          end
        end
        IF_BUSY: begin
          if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (mem_ack) begin
            // Hand the port straight to a pending data access: no idle bubble on mem_req.
            if (dm_req) begin
              state     <= DM_BUSY;
              mem_req   <= 1'b1;
              mem_addr  <= dm_addr;
              mem_we    <= dm_wstrb;
              mem_wdata <= dm_wdata;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end else begin
            mem_req <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (mem_ack) begin
            if (if_req) begin
              state     <= IF_BUSY;
              mem_req   <= 1'b1;
              mem_addr  <= if_addr;
              mem_we    <= '0;
              mem_wdata <= '0;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end else begin
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level memory/requester model plus directed cases.
module tb_mem_port_arbiter;
  localparam int TCYC = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        waiting;
  logic        err;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .waiting(waiting), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [logic [31:0]];
  bit          m_busy = 1'b0;
  bit          m_owner_dm = 1'b0;
  bit          stall = 1'b0;
  bit          just_tmo = 1'b0;
  int          m_cnt = 0;
  int          m_age = 0;
  int          fixed_lat = -1;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_we;
  logic        prev_if = 1'b0;
  logic        prev_dm = 1'b0;
  logic        prev_rst = 1'b0;
  int          if_acks = 0;
  int          dm_acks = 0;
  logic [31:0] last_if_data = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request levels the DUT saw at the last rising edge.
  always @(posedge clk) begin
    prev_if  <= if_req;
    prev_dm  <= dm_req;
    prev_rst <= rst;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: memory model reacts, DUT outputs are checked, requesters are driven.
  task automatic step(input bit auto_req);
    bit          exp_req;
    bit          tmo;
    bit          exp_ia;
    bit          exp_da;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    logic [31:0] w;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!m_busy) begin
      exp_req = prev_rst && (prev_if || prev_dm) && !just_tmo;
      check_val("mem_req_start", 32'(mem_req), 32'(exp_req));
      if (mem_req) begin
        m_busy     = 1'b1;
        m_age      = 0;
        m_owner_dm = prev_dm;
        m_addr     = mem_addr;
        m_we       = mem_we;
        m_wdata    = mem_wdata;
        m_cnt      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        if (m_owner_dm) begin
          check_val("dm_grant_addr", mem_addr, dm_addr);
          check_val("dm_grant_we", 32'(mem_we), 32'(dm_wstrb));
          if (dm_wstrb != 4'd0) check_val("dm_grant_wdata", mem_wdata, dm_wdata);
        end else begin
          check_val("if_grant_addr", mem_addr, if_addr);
          check_val("if_grant_we", 32'(mem_we), 32'd0);
        end
      end
    end else begin
      check_val("mem_req_hold", 32'(mem_req), 32'd1);
      check_val("mem_addr_hold", mem_addr, m_addr);
    end
    just_tmo = 1'b0;
    tmo      = 1'b0;
    if (m_busy) begin
      m_age++;
      if (!stall && m_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = (m_we == 4'd0) ? word_at(m_addr) : $urandom;
      end else begin
        m_cnt--;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      tmo = stall && (m_age == TCYC);
`endif
    end
    exp_ia  = m_busy && !m_owner_dm && (mem_ack || tmo);
    exp_da  = m_busy && m_owner_dm && (mem_ack || tmo);
    exp_ird = (exp_ia && !tmo) ? mem_rdata : 32'd0;
    exp_drd = (exp_da && !tmo) ? mem_rdata : 32'd0;
    #1;
    check_val("if_ack", 32'(if_ack), 32'(exp_ia));
    check_val("dm_ack", 32'(dm_ack), 32'(exp_da));
    check_val("if_rdata", if_rdata, exp_ird);
    check_val("dm_rdata", dm_rdata, exp_drd);
    check_val("err", 32'(err), 32'(tmo));
    check_val("waiting", 32'(waiting), 32'((if_req && !exp_ia) || (dm_req && !exp_da)));
    if_acks += int'(if_ack);
    dm_acks += int'(dm_ack);
    if (if_ack) last_if_data = if_rdata;
    if (exp_da && m_we != 4'd0 && !tmo) begin
      w = word_at(m_addr);
      for (int b = 0; b < 4; b++) if (m_we[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
      ref_mem[m_addr] = w;
    end
    if (mem_ack || tmo) begin
      m_busy   = 1'b0;
      just_tmo = tmo;
    end
    if (exp_ia) begin
      if_req = 1'b0;
    end else if (auto_req && !if_req && $urandom_range(0, 2) == 0) begin
      if_addr = 32'h100 + ($urandom_range(0, 63) << 2);
      if_req  = 1'b1;
    end
    if (exp_da) begin
      dm_req = 1'b0;
    end else if (auto_req && !dm_req && $urandom_range(0, 2) == 0) begin
      dm_addr  = 32'h2000 + ($urandom_range(0, 15) << 2);
      dm_wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      dm_wdata = $urandom;
      dm_req   = 1'b1;
    end
  endtask

  // Asserts reset between clock edges and checks that the port is released at once.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_if_ack", 32'(if_ack), 32'd0);
    check_val("rst_dm_ack", 32'(dm_ack), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    m_busy   = 1'b0;
    mem_ack  = 1'b0;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    stall    = 1'b0;
    just_tmo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_wstrb = 4'd0;
    dm_addr = 32'd0; dm_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_mem_req", 32'(mem_req), 32'd0);
    check_val("reset_mem_addr", mem_addr, 32'd0);
    check_val("reset_mem_we", 32'(mem_we), 32'd0);
    check_val("reset_mem_wdata", mem_wdata, 32'd0);
    check_val("reset_acks", 32'({if_ack, dm_ack, err}), 32'd0);
    check_val("reset_rdata", if_rdata | dm_rdata, 32'd0);
    check_val("reset_waiting", 32'(waiting), 32'd0);
    rst = 1'b1;

    // Fetch from 0x100 with memory latency 2.
    ref_mem[32'h100] = 32'h00500093;
    fixed_lat = 2; if_acks = 0;
    if_addr = 32'h100; if_req = 1'b1;
    repeat (5) step(1'b0);
    check_val("fetch_ack_count", 32'(if_acks), 32'd1);
    check_val("fetch_rdata", last_if_data, 32'h00500093);

    // Simultaneous requests: data first, then fetch with no bubble.
    fixed_lat = 1; if_acks = 0; dm_acks = 0;
    dm_addr = 32'h2000; dm_wstrb = 4'd0; dm_req = 1'b1;
    if_addr = 32'h104; if_req = 1'b1;
    repeat (8) step(1'b0);
    check_val("both_if_acks", 32'(if_acks), 32'd1);
    check_val("both_dm_acks", 32'(dm_acks), 32'd1);

    // Partial store.
    fixed_lat = 3; dm_acks = 0;
    dm_addr = 32'h2004; dm_wstrb = 4'b0011; dm_wdata = 32'hAABBCCDD; dm_req = 1'b1;
    repeat (6) step(1'b0);
    check_val("store_acks", 32'(dm_acks), 32'd1);
    w = word_at(32'h2004);
    check_val("store_low_half", {16'd0, w[15:0]}, 32'h0000CCDD);

    // Reset two cycles into a data access, then a clean fetch.
    fixed_lat = 10; dm_acks = 0;
    dm_addr = 32'h2008; dm_wstrb = 4'd0; dm_req = 1'b1;
    step(1'b0);
    step(1'b0);
    mid_reset();
    check_val("abandoned_dm_acks", 32'(dm_acks), 32'd0);
    fixed_lat = 1; if_acks = 0;
    if_addr = 32'h108; if_req = 1'b1;
    repeat (4) step(1'b0);
    check_val("post_reset_fetch", 32'(if_acks), 32'd1);

    // Memory never answers.
    if_acks = 0; stall = 1'b1;
    if_addr = 32'h180; if_req = 1'b1;
    repeat (TCYC + 4) step(1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
    check_val("timeout_acks", 32'(if_acks), 32'd1);
    stall = 1'b0;
`else
    check_val("stall_no_ack", 32'(if_acks), 32'd0);
    check_val("stall_mem_req", 32'(mem_req), 32'd1);
    check_val("stall_waiting", 32'(waiting), 32'd1);
    mid_reset();
`endif

    // Random traffic, then drain.
    fixed_lat = -1;
    repeat (3000) step(1'b1);
    repeat (20) step(1'b0);
    check_val("drained", 32'({if_req, dm_req}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
